// File: rtl/pmd_nrzi_lane.sv
// NRZI lane datapath: WIDTH-bit NRZ<->NRZI coding, signal-detect debounce,
// local loopback and transmit disable on a single clock.
module pmd_nrzi_lane #(
   parameter  int WIDTH       = 2,
   parameter  int SD_ASSERT   = 4,
   parameter  int SD_DEASSERT = 2,
   localparam int CW          = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] tx_nrzi,
   input  logic [WIDTH-1:0] rx_nrzi,
   input  logic [CW-1:0]    rx_count,
   input  logic             signal_detect,
   output logic [WIDTH-1:0] rx_data,
   output logic [CW-1:0]    rx_data_count,
   output logic             signal_status,
   input  logic [1:0]       loopback_mode
);

   localparam int SD_MAX = (SD_ASSERT > SD_DEASSERT) ? SD_ASSERT : SD_DEASSERT;
   localparam int DW     = $clog2(SD_MAX + 1);

   localparam logic [CW-1:0] WMAX  = CW'(WIDTH);
   localparam logic [DW-1:0] THR_A = DW'(SD_ASSERT);
   localparam logic [DW-1:0] THR_D = DW'(SD_DEASSERT);

   typedef enum logic [1:0] {
      M_NORM  = 2'd0,
      M_LOOP  = 2'd1,
      M_TXOFF = 2'd2
   } mode_e;

   logic [WIDTH-1:0] r_e;
   logic             r_dec;
   logic             r_deb;
   logic [DW-1:0]    r_cnt;
   mode_e            r_prev_mode;

   mode_e            w_mode;
   logic [WIDTH-1:0] w_e;
   logic             w_lvl;
   logic [CW-1:0]    w_rx_cnt;
   logic [CW-1:0]    w_cnt;
   logic [WIDTH-1:0] w_in;
   logic [WIDTH-1:0] w_d;
   logic             w_last;
   logic             w_dec_nxt;
   logic             w_flush;
   logic [DW-1:0]    w_cnt_inc;
   logic [DW-1:0]    w_thr;

   // Reserved mode 3 behaves exactly like normal mode, including for flush
   always_comb begin
      w_mode = M_NORM;
      unique case (loopback_mode)
         2'd1:    w_mode = M_LOOP;
         2'd2:    w_mode = M_TXOFF;
         default: w_mode = M_NORM;
      endcase
   end

   // The encoder state is the last line bit of the previous word
   always_comb begin
      w_lvl = r_e[WIDTH-1];
      w_e   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_lvl  = w_lvl ^ tx_data[i];
         w_e[i] = w_lvl;
      end
   end

   assign w_rx_cnt = (rx_count > WMAX) ? WMAX : rx_count;
   assign w_in     = (w_mode == M_LOOP) ? r_e : rx_nrzi;
   assign w_cnt    = (w_mode == M_LOOP) ? WMAX : w_rx_cnt;

   always_comb begin
      w_d       = '0;
      w_last    = r_dec;
      w_dec_nxt = r_dec;
      for (int i = 0; i < WIDTH; i++) begin
         if (CW'(i) < w_cnt) begin
            w_d[i]    = w_in[i] ^ w_last;
            w_last    = w_in[i];
            w_dec_nxt = w_in[i];
         end
      end
   end

   assign w_flush = ((w_mode != M_LOOP) && !r_deb) ||
                    (w_mode != r_prev_mode);

   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_thr     = r_deb ? THR_D : THR_A;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_e           <= '0;
         tx_nrzi       <= '0;
         r_dec         <= 1'b0;
         rx_data       <= '0;
         rx_data_count <= '0;
         r_deb         <= 1'b0;
         r_cnt         <= '0;
         signal_status <= 1'b0;
         r_prev_mode   <= M_NORM;
      end else begin
         r_e         <= w_e;
         tx_nrzi     <= (w_mode == M_NORM) ? w_e : '0;
         r_prev_mode <= w_mode;

         if (w_flush) begin
            r_dec         <= 1'b0;
            rx_data       <= '0;
            rx_data_count <= '0;
         end else begin
            r_dec         <= w_dec_nxt;
            rx_data       <= w_d;
            rx_data_count <= w_cnt;
         end

         signal_status <= (w_mode == M_LOOP) | r_deb;

         // Count disagreement run length; agreement restarts the run
         if (signal_detect != r_deb) begin
            if (w_cnt_inc == w_thr) begin
               r_deb <= ~r_deb;
               r_cnt <= '0;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pmd_nrzi_lane.sv
// Bench for pmd_nrzi_lane: behavioural model feeding a scoreboard queue,
// plus directed checks of encode, debounce, decode, loopback and reset.
module tb_pmd_nrzi_lane;

   localparam int W  = 2;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  tx_data;
   logic [W-1:0]  tx_nrzi;
   logic [W-1:0]  rx_nrzi;
   logic [CW-1:0] rx_count;
   logic          signal_detect;
   logic [W-1:0]  rx_data;
   logic [CW-1:0] rx_data_count;
   logic          signal_status;
   logic [1:0]    loopback_mode;

   always #5 clk = ~clk;

   pmd_nrzi_lane #(
      .WIDTH(2), .SD_ASSERT(4), .SD_DEASSERT(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tx_data(tx_data),
      .tx_nrzi(tx_nrzi),
      .rx_nrzi(rx_nrzi),
      .rx_count(rx_count),
      .signal_detect(signal_detect),
      .rx_data(rx_data),
      .rx_data_count(rx_data_count),
      .signal_status(signal_status),
      .loopback_mode(loopback_mode)
   );

   typedef struct packed {
      logic [W-1:0]  tx;
      logic [W-1:0]  rxd;
      logic [CW-1:0] rxc;
      logic          st;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;

   logic         m_lvl;
   logic [W-1:0] m_ereg;
   logic         m_dec;
   logic         m_deb;
   int           m_cnt;
   int           m_pmode;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_push();
      exp_t         x;
      int           md;
      int           n;
      logic [W-1:0] e;
      logic [W-1:0] in;
      logic         lvl;
      logic         last;
      x = '0;
      if (rst) begin
         m_lvl = 0; m_ereg = '0; m_dec = 0;
         m_deb = 0; m_cnt = 0;   m_pmode = 0;
      end else begin
         md  = (loopback_mode == 2'd3) ? 0 : int'(loopback_mode);
         lvl = m_lvl;
         for (int i = 0; i < W; i++) begin
            if (tx_data[i]) lvl = ~lvl;
            e[i] = lvl;
         end
         x.tx = (md == 0) ? e : '0;
         if (md == 1) begin
            in = m_ereg; n = W;
         end else begin
            in = rx_nrzi;
            n  = (int'(rx_count) > W) ? W : int'(rx_count);
         end
         if ((md != 1 && !m_deb) || md != m_pmode) begin
            m_dec = 0;
         end else begin
            last = m_dec;
            for (int i = 0; i < n; i++) begin
               x.rxd[i] = (in[i] != last);
               last     = in[i];
            end
            m_dec = last;
            x.rxc = CW'(n);
         end
         x.st = (md == 1) || m_deb;
         if (signal_detect != m_deb) begin
            m_cnt++;
            if (m_cnt == (m_deb ? 2 : 4)) begin
               m_deb = ~m_deb;
               m_cnt = 0;
            end
         end else begin
            m_cnt = 0;
         end
         m_lvl   = e[W-1];
         m_ereg  = e;
         m_pmode = md;
      end
      sb.push_back(x);
   endtask

   task automatic step();
      exp_t x;
      model_push();
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         x = sb.pop_front();
         chk("sb_tx_nrzi", tx_nrzi, x.tx);
         chk("sb_rx_data", rx_data, x.rxd);
         chk("sb_rx_count", rx_data_count, x.rxc);
         chk("sb_status", signal_status, x.st);
      end
   endtask

   task automatic cyc(input logic [1:0] t, input logic [1:0] rn,
                      input logic [1:0] rc, input logic sd,
                      input logic [1:0] md);
      tx_data = t; rx_nrzi = rn; rx_count = rc;
      signal_detect = sd; loopback_mode = md;
      step();
   endtask

   logic [W-1:0] hist[0:31];
   logic [1:0]   t;

   initial begin
      rst = 1'b1; tx_data = '0; rx_nrzi = '0; rx_count = '0;
      signal_detect = 1'b0; loopback_mode = 2'd0;
      step(); step();
      chk("rst_tx", tx_nrzi, 0);
      chk("rst_status", signal_status, 0);
      rst = 1'b0;
      cyc(2'b00, 2'b00, 2'd0, 1'b0, 2'd0);
      cyc(2'b00, 2'b00, 2'd0, 1'b0, 2'd0);
      chk("idle_tx", tx_nrzi, 0);
      chk("idle_rxc", rx_data_count, 0);
      chk("idle_status", signal_status, 0);

      for (int i = 0; i < 3; i++) begin
         cyc(2'b11, 2'b00, 2'd0, 1'b0, 2'd0);
         chk("enc_11", tx_nrzi, 2'b01);
      end
      cyc(2'b01, 2'b00, 2'd0, 1'b0, 2'd0);
      chk("enc_01", tx_nrzi, 2'b11);

      for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00, 2'd0, 1'b1, 2'd0);
      cyc(2'b00, 2'b00, 2'd0, 1'b0, 2'd0);
      chk("glitch_status", signal_status, 0);
      for (int i = 1; i <= 5; i++) begin
         cyc(2'b00, 2'b00, 2'd0, 1'b1, 2'd0);
         if (i == 4) chk("deb_pre", signal_status, 0);
      end
      chk("deb_up", signal_status, 1);
      cyc(2'b00, 2'b00, 2'd0, 1'b0, 2'd0);
      cyc(2'b00, 2'b00, 2'd0, 1'b1, 2'd0);
      chk("deb_hold", signal_status, 1);
      cyc(2'b00, 2'b00, 2'd0, 1'b0, 2'd0);
      cyc(2'b00, 2'b00, 2'd0, 1'b0, 2'd0);
      chk("deb_fall_pre", signal_status, 1);
      cyc(2'b00, 2'b00, 2'd0, 1'b0, 2'd0);
      chk("deb_down", signal_status, 0);

      for (int i = 0; i < 5; i++) cyc(2'b00, 2'b00, 2'd0, 1'b1, 2'd0);
      chk("vc_status", signal_status, 1);
      cyc(2'b00, 2'b11, 2'd2, 1'b1, 2'd0);
      chk("vc0_cnt", rx_data_count, 2);
      chk("vc0_data", rx_data, 2'b01);
      cyc(2'b00, 2'b00, 2'd0, 1'b1, 2'd0);
      chk("vc1_cnt", rx_data_count, 0);
      chk("vc1_data", rx_data, 2'b00);
      cyc(2'b00, 2'b00, 2'd1, 1'b1, 2'd0);
      chk("vc2_cnt", rx_data_count, 1);
      chk("vc2_data", rx_data, 2'b01);
      cyc(2'b00, 2'b10, 2'd2, 1'b1, 2'd0);
      chk("vc3_cnt", rx_data_count, 2);
      chk("vc3_data", rx_data, 2'b10);
      cyc(2'b00, 2'b01, 2'd3, 1'b1, 2'd0);
      chk("clamp_cnt", rx_data_count, 2);
      chk("clamp_data", rx_data, 2'b10);

      for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00, 2'd0, 1'b0, 2'd0);
      chk("lb_pre_status", signal_status, 0);
      for (int k = 0; k <= 20; k++) begin
         t = 2'($urandom_range(0, 3));
         hist[k] = t;
         cyc(t, 2'b00, 2'd0, 1'b0, 2'd1);
         if (k == 0) begin
            chk("lb_flush_cnt", rx_data_count, 0);
            chk("lb_tx_off", tx_nrzi, 0);
            chk("lb_status", signal_status, 1);
         end
         if (k >= 2) begin
            chk("lb_data", rx_data, hist[k-1]);
            chk("lb_cnt", rx_data_count, 2);
         end
      end

      for (int i = 0; i < 6; i++) begin
         cyc(2'b11, 2'($urandom_range(0, 3)), 2'd2, 1'b1, 2'd2);
         chk("m2_tx_off", tx_nrzi, 0);
      end
      chk("m2_rx_cnt", rx_data_count, 2);
      cyc(2'b01, 2'b10, 2'd2, 1'b1, 2'd0);
      chk("m2to0_flush", rx_data_count, 0);
      cyc(2'b01, 2'b10, 2'd2, 1'b1, 2'd0);
      chk("m0_cnt", rx_data_count, 2);
      cyc(2'b01, 2'b10, 2'd2, 1'b1, 2'd3);
      chk("m0to3_noflush", rx_data_count, 2);

      cyc(2'b11, 2'b11, 2'd2, 1'b1, 2'd0);
      rst = 1'b1;
      cyc(2'b11, 2'b11, 2'd2, 1'b1, 2'd0);
      chk("rst_mid_tx", tx_nrzi, 0);
      chk("rst_mid_rxd", rx_data, 0);
      chk("rst_mid_rxc", rx_data_count, 0);
      chk("rst_mid_status", signal_status, 0);
      rst = 1'b0;

      for (int i = 0; i < 60; i++) begin
         cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), ($urandom_range(0, 9) > 2),
             (i % 12 == 0) ? 2'($urandom_range(0, 3)) : loopback_mode);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
